// File: rtl/al_accel_pkg.sv
// Shared definitions for the al_accel accumulation controller: state encoding,
// default sizing and matrix geometry.
package al_accel_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int PIPE_LAT_DEF = 2;
    localparam int ACC_DIM      = 3;
    // Wide enough for the largest legal PIPE_LAT of 15.
    localparam int DRAIN_W      = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_BIAS   = 3'd1;
    localparam logic [2:0] ST_ACCUM  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        BIAS   = ST_BIAS,
        ACCUM  = ST_ACCUM,
        DRAIN  = ST_DRAIN,
        RESULT = ST_RESULT
    } acc_state_e;

endpackage

// File: rtl/al_accel_drain_cnt.sv
// Loadable down-counter with a zero flag; times the pipeline drain of a tile.
module al_accel_drain_cnt
    import al_accel_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DRAIN_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [DRAIN_W-1:0] cnt_q;
    logic [DRAIN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/al_accel_acc_ctrl.sv
// Tile sequencer for the accumulator matrix: bias load, N handshaked input
// passes, fixed-length pipeline drain, then a held result until consumed.
module al_accel_acc_ctrl
    import al_accel_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_num_pass,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_matrix_bps_load,
    output logic             acc_matrix_inter_sum_load,
    output logic             acc_enb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [2:0]       dbg_state
);

    // Handshakes: a window transfers on in_valid & in_ready; the result is
    // taken on out_valid & out_ready. Neither side may depend on the other's
    // ready before raising its valid.

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] pass_inc;
    logic             drain_load;
    logic             drain_dec;
    logic             drain_zero;

    assign pass_inc = pass_cnt_q + CNT_W'(1);

    always_comb begin
        state_d                   = state_q;
        n_d                       = n_q;
        pass_cnt_d                = pass_cnt_q;
        done_d                    = 1'b0;
        in_ready                  = 1'b0;
        acc_matrix_bps_load       = 1'b0;
        acc_matrix_inter_sum_load = 1'b0;
        acc_enb                   = 1'b0;
        out_valid                 = 1'b0;
        drain_load                = 1'b0;
        drain_dec                 = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_num_pass != '0) begin
                        n_d        = cfg_num_pass;
                        pass_cnt_d = '0;
                        state_d    = BIAS;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BIAS: begin
                acc_matrix_bps_load = 1'b1;
                acc_enb             = 1'b1;
                state_d             = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                // Pipeline only advances on a transfer, so upstream gaps stall it.
                if (in_valid) begin
                    acc_matrix_inter_sum_load = 1'b1;
                    acc_enb                   = 1'b1;
                    pass_cnt_d                = pass_inc;
                    if (pass_inc == n_q) begin
                        drain_load = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                acc_enb = 1'b1;
                if (drain_zero) begin
                    state_d = RESULT;
                end else begin
                    drain_dec = 1'b1;
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            pass_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            pass_cnt_q <= pass_cnt_d;
            done_q     <= done_d;
        end
    end

    // Loaded with PIPE_LAT-1 so DRAIN lasts exactly PIPE_LAT cycles.
    al_accel_drain_cnt u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (drain_load),
        .load_val (DRAIN_W'(PIPE_LAT - 1)),
        .dec      (drain_dec),
        .zero     (drain_zero)
    );

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pass_cnt  = pass_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_al_accel_acc_ctrl.sv
// Directed bench for al_accel_acc_ctrl: per-cycle expected output words are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_al_accel_acc_ctrl;

    localparam int CNT_W = 8;
    localparam int W     = 18;

    // Flag order: {bps_load, inter_sum_load, acc_enb, in_ready, out_valid, busy, done}
    localparam logic [6:0] F_BIAS   = 7'b1010010;
    localparam logic [6:0] F_ACC_HS = 7'b0111010;
    localparam logic [6:0] F_ACC_ST = 7'b0001010;
    localparam logic [6:0] F_DRAIN  = 7'b0010010;
    localparam logic [6:0] F_RES    = 7'b0000110;
    localparam logic [6:0] F_DONE   = 7'b0000001;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] cfg_num_pass;
    logic             in_valid;
    logic             in_ready;
    logic             acc_matrix_bps_load;
    logic             acc_matrix_inter_sum_load;
    logic             acc_enb;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [2:0]       dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_compared   = 0;
    int           n_mismatched = 0;
    logic         mon_en       = 1'b0;

    al_accel_acc_ctrl #(.CNT_W(CNT_W), .PIPE_LAT(2)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .cfg_num_pass              (cfg_num_pass),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .acc_matrix_bps_load       (acc_matrix_bps_load),
        .acc_matrix_inter_sum_load (acc_matrix_inter_sum_load),
        .acc_enb                   (acc_enb),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .busy                      (busy),
        .done                      (done),
        .pass_cnt                  (pass_cnt),
        .dbg_state                 (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] obs_now();
        return {dbg_state, acc_matrix_bps_load, acc_matrix_inter_sum_load, acc_enb,
                in_ready, out_valid, busy, done, pass_cnt};
    endfunction

    task automatic push(input logic [2:0] st, input logic [6:0] flags, input logic [7:0] pc);
        exp_q.push_back({st, flags, pc});
    endtask

    // One clock cycle of input stimulus.
    task automatic cyc(input logic st, input logic [7:0] cfg, input logic iv, input logic ordy);
        start        = st;
        cfg_num_pass = cfg;
        in_valid     = iv;
        out_ready    = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Quiet cycles, then every queued expectation must have been consumed.
    task automatic idle_and_drain(input string name, input int n);
        repeat (n) cyc(1'b0, 8'd0, 1'b0, 1'b0);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL %s_drain: %0d expected words left, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // Monitor: every cycle where the controller is busy or pulsing done is checked.
    always @(negedge clk) begin
        if (mon_en && (busy === 1'b1 || done === 1'b1)) begin
            logic [W-1:0] got;
            logic [W-1:0] want;
            got = obs_now();
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL unexpected_activity: got %h expected no activity", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_mismatched++;
                    $display("FAIL cycle_word: got %h expected %h (t=%0t)", got, want, $time);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        cfg_num_pass = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_outputs", obs_now(), '0);
        reset  = 1'b0;
        mon_en = 1'b1;
        cyc(1'b0, 8'd0, 1'b0, 1'b0);

        // N=3, continuous valid; a start with cfg=1 during ACCUM must be ignored.
        push(3'd1, F_BIAS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd1);
        push(3'd2, F_ACC_HS, 8'd2);
        push(3'd3, F_DRAIN, 8'd3);
        push(3'd3, F_DRAIN, 8'd3);
        push(3'd4, F_RES, 8'd3);
        push(3'd0, F_DONE, 8'd3);
        cyc(1'b1, 8'd3, 1'b1, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        cyc(1'b1, 8'd1, 1'b1, 1'b1);
        repeat (5) cyc(1'b0, 8'd0, 1'b1, 1'b1);
        idle_and_drain("n3_stream", 4);

        // N=3 with stalls: valid pattern 1,0,0,1,0,1 over the ACCUM cycles.
        push(3'd1, F_BIAS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd0);
        push(3'd2, F_ACC_ST, 8'd1);
        push(3'd2, F_ACC_ST, 8'd1);
        push(3'd2, F_ACC_HS, 8'd1);
        push(3'd2, F_ACC_ST, 8'd2);
        push(3'd2, F_ACC_HS, 8'd2);
        push(3'd3, F_DRAIN, 8'd3);
        push(3'd3, F_DRAIN, 8'd3);
        push(3'd4, F_RES, 8'd3);
        push(3'd0, F_DONE, 8'd3);
        cyc(1'b1, 8'd3, 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        begin
            logic [5:0] pat;
            pat = 6'b101001;
            for (int i = 0; i < 6; i++) cyc(1'b0, 8'd0, pat[i], 1'b1);
        end
        repeat (4) cyc(1'b0, 8'd0, 1'b0, 1'b1);
        idle_and_drain("n3_stalls", 4);

        // Zero-pass start pulses done only; a start in that done cycle is accepted.
        push(3'd0, F_DONE, 8'd3);
        push(3'd1, F_BIAS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd0);
        push(3'd3, F_DRAIN, 8'd1);
        push(3'd3, F_DRAIN, 8'd1);
        push(3'd4, F_RES, 8'd1);
        push(3'd0, F_DONE, 8'd1);
        cyc(1'b1, 8'd0, 1'b0, 1'b1);
        cyc(1'b1, 8'd1, 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        repeat (4) cyc(1'b0, 8'd0, 1'b0, 1'b1);
        idle_and_drain("zero_pass_then_n1", 4);

        // N=2 with the consumer holding off for 5 RESULT cycles.
        push(3'd1, F_BIAS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd1);
        push(3'd3, F_DRAIN, 8'd2);
        push(3'd3, F_DRAIN, 8'd2);
        repeat (6) push(3'd4, F_RES, 8'd2);
        push(3'd0, F_DONE, 8'd2);
        cyc(1'b1, 8'd2, 1'b1, 1'b0);
        repeat (10) cyc(1'b0, 8'd0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        idle_and_drain("n2_backpressure", 4);

        // N=4 aborted by reset in the second ACCUM cycle, then a clean N=1 tile.
        push(3'd1, F_BIAS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd1);
        cyc(1'b1, 8'd4, 1'b1, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        cyc(1'b1, 8'd7, 1'b1, 1'b1);
        reset = 1'b1;
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        reset = 1'b0;
        check_now("after_reset_outputs", obs_now(), '0);
        idle_and_drain("reset_abort", 4);

        push(3'd1, F_BIAS, 8'd0);
        push(3'd2, F_ACC_HS, 8'd0);
        push(3'd3, F_DRAIN, 8'd1);
        push(3'd3, F_DRAIN, 8'd1);
        push(3'd4, F_RES, 8'd1);
        push(3'd0, F_DONE, 8'd1);
        cyc(1'b1, 8'd1, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 8'd0, 1'b1, 1'b1);
        idle_and_drain("n1_after_reset", 4);

        // N=255: full-range pass count with no wrap.
        push(3'd1, F_BIAS, 8'd0);
        for (int i = 0; i < 255; i++) push(3'd2, F_ACC_HS, 8'(i));
        push(3'd3, F_DRAIN, 8'd255);
        push(3'd3, F_DRAIN, 8'd255);
        push(3'd4, F_RES, 8'd255);
        push(3'd0, F_DONE, 8'd255);
        cyc(1'b1, 8'd255, 1'b1, 1'b1);
        repeat (261) cyc(1'b0, 8'd0, 1'b1, 1'b1);
        idle_and_drain("n255", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
